// File: rtl/riscv_imm_pkg.sv
// Shared RISC-V immediate format codes plus the pack/range-check helpers
// used by the program-loader encoder and its testbenches.
package riscv_imm_pkg;

  localparam int INSTR_W = 32;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Scatter imm into the format's immediate slots; every other bit comes from base.
  function automatic logic [31:0] imm_pack(input logic [1:0]  fmt,
                                           input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] word;
    case (fmt)
      IMM_I:   word = {imm[11:0], base[19:0]};
      IMM_S:   word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      IMM_B:   word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      default: word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
    endcase
    return word;
  endfunction

  // True when the extender would reproduce imm exactly from the packed word.
  function automatic logic imm_fits(input logic [1:0]  fmt,
                                    input logic [31:0] imm);
    logic ok;
    case (fmt)
      IMM_I, IMM_S: ok = (imm[31:11] == {21{imm[31]}});
      IMM_B:        ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
      default:      ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry first-word-fall-through FIFO; the head entry is a register so
// the consumer sees registered data.
module instr_fifo2
  import riscv_imm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] push_data,
  output logic               full,
  output logic               empty,
  output logic [INSTR_W-1:0] head_data
);

  logic [INSTR_W-1:0] head_q, head_d;
  logic [INSTR_W-1:0] tail_q, tail_d;
  logic               head_vld_q, head_vld_d;
  logic               tail_vld_q, tail_vld_d;

  // Pop is applied first so a push in the same cycle lands behind the survivor.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
    end else begin
      if (pop && head_vld_q) begin
        head_d     = tail_q;
        head_vld_d = tail_vld_q;
        tail_vld_d = 1'b0;
      end
      if (push && !tail_vld_q) begin
        if (head_vld_d) begin
          tail_d     = push_data;
          tail_vld_d = 1'b1;
        end else begin
          head_d     = push_data;
          head_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign full      = tail_vld_q;
  assign empty     = !head_vld_q;
  assign head_data = head_q;

endmodule

// File: rtl/immediate_encoder.sv
// Program-loader immediate encoder: range-checks and packs immediates into
// template instructions, buffers them and hands out sequential write addresses.
module immediate_encoder
  import riscv_imm_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ImmSrc,
  input  logic [31:0]       imm_value,
  input  logic [31:0]       base_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              range_err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              fits;
  logic              push;
  logic              pop;
  logic [31:0]       packed_word;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              range_err_q, range_err_d;

  assign in_ready    = !fifo_full && !clear;
  assign accept      = in_valid && in_ready;
  assign fits        = imm_fits(ImmSrc, imm_value);
  assign packed_word = imm_pack(ImmSrc, imm_value, base_instr);
  assign push        = accept && fits;
  assign pop         = out_valid && out_ready && !clear;

  instr_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (packed_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (instr_out)
  );

  // Rejected requests are still consumed; they only bump the saturating counter.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    err_count_d = err_count_q;
    range_err_d = accept && !fits;
    if (clear) begin
      wr_addr_d   = BASE;
      err_count_d = 8'd0;
      range_err_d = 1'b0;
    end else begin
      if (pop) begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
      if (range_err_d && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q   <= BASE;
      err_count_q <= 8'd0;
      range_err_q <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      err_count_q <= err_count_d;
      range_err_q <= range_err_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign wr_addr   = wr_addr_q;
  assign range_err = range_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: directed vector table, handshake
// corner sequences and randomized traffic against a queue-based reference.
module tb_immediate_encoder;
  import riscv_imm_pkg::*;

  localparam int ADDR_W    = 2;
  localparam int BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        imm_src;
  logic [31:0]       imm_value;
  logic [31:0]       base_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] wr_addr;
  logic              range_err;
  logic [7:0]        err_count;

  immediate_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ImmSrc     (imm_src),
    .imm_value  (imm_value),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .wr_addr    (wr_addr),
    .range_err  (range_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  typedef struct {
    logic [1:0]  fmt;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  req_t sb[$];
  int   m_addr;
  int   m_errs;
  logic m_rerr;
  bit   acc;
  int   accepted;
  logic [31:0] r;
  vec_t vecs[13];

  // Decode side of the core: what the extender recovers from an instruction.
  function automatic logic [31:0] ref_extend(input logic [1:0] fmt, input logic [31:0] i);
    case (fmt)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] ref_mask(input logic [1:0] fmt);
    case (fmt)
      IMM_I:        return 32'hFFF0_0000;
      IMM_S, IMM_B: return 32'hFE00_0F80;
      default:      return 32'hFFFF_F000;
    endcase
  endfunction

  function automatic bit ref_fits(input logic [1:0] fmt, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (fmt)
      IMM_I, IMM_S: return (v >= -2048) && (v <= 2047);
      IMM_B:        return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      default:      return (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic check_state();
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
    checkOutput("range_err", {31'd0, range_err}, {31'd0, m_rerr});
    checkOutput("err_count", {24'd0, err_count}, m_errs);
    checkOutput("wr_addr", {30'd0, wr_addr}, m_addr);
    if (sb.size() > 0) begin
      checkOutput("roundtrip_imm", ref_extend(sb[0].fmt, instr_out), sb[0].imm);
      checkOutput("template_bits", instr_out & ~ref_mask(sb[0].fmt),
                  sb[0].base & ~ref_mask(sb[0].fmt));
    end
  endtask

  // One clock of traffic: checks in_ready, advances the model across the edge.
  task automatic applyStimulus(output bit accepted_o);
    bit   exp_ready;
    bit   pop;
    bit   fits;
    req_t req;
    #1;
    exp_ready = (sb.size() < 2) && !clear;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    accepted_o = in_valid && exp_ready;
    pop        = (sb.size() > 0) && out_ready;
    fits       = ref_fits(imm_src, imm_value);
    req        = '{imm_src, imm_value, base_instr};
    @(posedge clk);
    #1;
    if (clear) begin
      sb.delete();
      m_addr = BASE_ADDR;
      m_errs = 0;
      m_rerr = 1'b0;
    end else begin
      if (pop) begin
        sb.delete(0);
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end
      if (accepted_o && fits) sb.push_back(req);
      m_rerr = accepted_o && !fits;
      if (m_rerr && m_errs < 255) m_errs++;
    end
    check_state();
  endtask

  initial begin
    vecs[0]  = '{IMM_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
    vecs[1]  = '{IMM_S, 32'h0000_0024, 32'h0000_2023, 32'h0200_2223, 1'b0};
    vecs[2]  = '{IMM_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    vecs[3]  = '{IMM_J, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0};
    vecs[4]  = '{IMM_J, 32'h0000_0003, 32'h0000_006F, 32'h0000_0000, 1'b1};
    vecs[5]  = '{IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h0000_0000, 1'b1};
    vecs[6]  = '{IMM_I, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
    vecs[7]  = '{IMM_B, 32'h0000_1000, 32'h0000_0063, 32'h0000_0000, 1'b1};
    vecs[8]  = '{IMM_B, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0};
    vecs[9]  = '{IMM_J, 32'h0010_0000, 32'h0000_006F, 32'h0000_0000, 1'b1};
    vecs[10] = '{IMM_J, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0};
    vecs[11] = '{IMM_S, 32'hFFFF_F7FF, 32'h0000_2023, 32'h0000_0000, 1'b1};
    vecs[12] = '{IMM_B, 32'h0000_0002, 32'h0000_0063, 32'h0000_0163, 1'b0};

    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm_src = IMM_I; imm_value = '0; base_instr = '0;
    m_addr = BASE_ADDR; m_errs = 0; m_rerr = 1'b0;

    #2 reset = 1'b1;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_instr_out", instr_out, 32'd0);
    checkOutput("rst_wr_addr", {30'd0, wr_addr}, BASE_ADDR);
    checkOutput("rst_range_err", {31'd0, range_err}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      in_valid = 1'b1; imm_src = vecs[i].fmt;
      imm_value = vecs[i].imm; base_instr = vecs[i].base;
      applyStimulus(acc);
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_err", i), {31'd0, range_err}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].exp_err)
        checkOutput($sformatf("vec%0d_instr", i), instr_out, vecs[i].exp_instr);
      applyStimulus(acc);
    end

    $display("[TB] backpressure and address wrap");
    clear = 1'b1; applyStimulus(acc); clear = 1'b0;
    out_ready = 1'b0; accepted = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; imm_src = IMM_I;
      imm_value = 32'd100 + accepted; base_instr = 32'h0000_0013;
      applyStimulus(acc);
      if (acc) accepted++;
    end
    checkOutput("held_third_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (accepted < 5 || sb.size() > 0); c++) begin
      in_valid = (accepted < 5);
      imm_value = 32'd100 + accepted;
      applyStimulus(acc);
      if (acc) accepted++;
    end
    in_valid = 1'b0;
    checkOutput("wrap_drained", {31'd0, out_valid}, 32'd0);
    checkOutput("wrap_final_addr", {30'd0, wr_addr}, 32'd1);

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; imm_src = IMM_S; imm_value = 32'd7; base_instr = 32'h0000_2023;
      applyStimulus(acc);
    end
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    sb.delete(); m_addr = BASE_ADDR; m_errs = 0; m_rerr = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) applyStimulus(acc);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      imm_src   = 2'($urandom_range(0, 3));
      r         = $urandom;
      case ($urandom_range(0, 3))
        0:       imm_value = $urandom;
        1:       imm_value = {{20{r[11]}}, r[11:0]};
        2:       imm_value = {{19{r[12]}}, r[12:0]};
        default: imm_value = {{11{r[20]}}, r[20:0]};
      endcase
      if ($urandom_range(0, 1) == 1) imm_value[0] = 1'b0;
      base_instr = $urandom;
      applyStimulus(acc);
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) applyStimulus(acc);

    $display("[TB] error saturation and clear");
    in_valid = 1'b1; imm_src = IMM_J; imm_value = 32'h0000_0003; base_instr = 32'h0000_006F;
    for (int c = 0; c < 260; c++) applyStimulus(acc);
    checkOutput("sat_err_count", {24'd0, err_count}, 32'd255);
    out_ready = 1'b0; imm_src = IMM_I; imm_value = 32'd1;
    applyStimulus(acc);
    checkOutput("preclear_valid", {31'd0, out_valid}, 32'd1);
    clear = 1'b1;
    applyStimulus(acc);
    clear = 1'b0; in_valid = 1'b0;
    checkOutput("clear_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("clear_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("clear_wr_addr", {30'd0, wr_addr}, BASE_ADDR);
    out_ready = 1'b1;
    repeat (2) applyStimulus(acc);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/immediate_encoder.md
# immediate_encoder

Packs a 32-bit signed immediate into the RISC-V I/S/B/J instruction bit positions selected by `ImmSrc`, merging it with the non-immediate fields of a template instruction. It is the inverse of the core's immediate extender. It sits in the program-loader path, in front of instruction memory: it range-checks each immediate, buffers encoded words in a 2-entry FIFO with valid/ready handshakes, and supplies the sequential write address for each word.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width.
- `BASE_ADDR`, default 0: address of the first word after reset or `clear`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of FIFO, address counter and error count.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `ImmSrc`  in  2  format select: 00=I, 01=S, 10=B, 11=J.
- `imm_value`  in  32  signed immediate (byte offset for B/J).
- `base_instr`  in  32  template word; its immediate bit positions are ignored.
- `out_valid`  out  1  head FIFO entry valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `instr_out`  out  32  encoded instruction at the FIFO head.
- `wr_addr`  out  ADDR_W  address for `instr_out`.
- `range_err`  out  1  one-cycle pulse when an accepted request fails the range check.
- `err_count`  out  8  count of rejected requests; saturates at 255.

## Operation
- **Bit scatter.** Every bit not listed below is taken from `base_instr`.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- **Range check.** A request passes only if:
  - I/S: imm[31:11] is all equal.
  - B: imm[31:12] is all equal and imm[0]=0.
  - J: imm[31:20] is all equal and imm[0]=0.
- **Round-trip property.** For every passing request, the core's extender applied to `instr_out` with the same `ImmSrc` returns `imm_value` exactly.
- **Accepted, passing request.** Pushed into the FIFO.
- **Accepted, failing request.** Consumed but not pushed. `range_err` pulses for one cycle. `err_count` increments unless already at 255.
- **`in_ready`** is (FIFO occupancy < 2) && !`clear`. It does not depend on `out_ready`.
- **Output handshake.** When `out_valid && out_ready`, the head entry is popped and `wr_addr` increments modulo 2^ADDR_W.
- **Simultaneous push and pop at occupancy 1.** Occupancy stays 1 and order is preserved.
- **At occupancy 2.** Push is impossible (`in_ready`=0); pop-only is allowed.
- **`clear`.** Wins over every other event in that cycle: FIFO emptied, `wr_addr`=BASE_ADDR, `err_count`=0, `range_err`=0, and no request is accepted.
- **`reset` values.** `out_valid`=0, `instr_out`=0, `wr_addr`=BASE_ADDR, `range_err`=0, `err_count`=0, FIFO empty. `in_ready` returns to 1 on the first cycle after reset is released.
- **`reset` mid-operation.** Buffered words are discarded; none is emitted after release.

## Timing
- Request accepted at edge N → `out_valid`=1 with its word from after edge N when the FIFO was empty: one cycle of latency.
- `range_err` is high for exactly the cycle after edge N.
- `instr_out` and `wr_addr` stay stable while `out_valid && !out_ready`.
- All outputs are registered, except `in_ready`, which is combinational from occupancy and `clear`.
- Throughput is one word per cycle when `out_ready` is held at 1.

## Structure
- **Package `riscv_imm_pkg`:**
  - `ImmSrc` constants `IMM_I`, `IMM_S`, `IMM_B`, `IMM_J`.
  - Pure functions `imm_pack(fmt, imm, base)` and `imm_fits(fmt, imm)`, shared with testbenches.
- **Sub-module `instr_fifo2`:** 2-entry FIFO holding 32-bit data, with push, pop, flush, full and empty signals.
- The top level holds the packing and check logic, the address counter and the error counter.

## Test plan
- **I format.** ImmSrc=00, imm=0xFFFFF800, base=0x00000013 → `instr_out`=0x80000013, `wr_addr`=0, `out_valid` one cycle after acceptance.
- **S and B formats.**
  - S: imm=0x00000024, base=0x00002023 → 0x02002223.
  - B: imm=0xFFFFFFFC, base=0x00000063 → 0xFE000EE3.
- **J format and range errors.**
  - J: imm=0x00000800, base=0x0000006F → 0x0010006F.
  - J with imm=0x00000003 → `range_err` pulse, `err_count`=1, no word emitted.
  - I with imm=0x00000800 → `err_count`=2.
- **Backpressure and wrap.** ADDR_W=2, `out_ready`=0, offer 3 requests → `in_ready` drops after 2 and the third is held. Then set `out_ready`=1 → 3 words in order at `wr_addr` 0,1,2; a fourth word appears at 3, a fifth at 0.
- **Saturation and clear.** Issue 260 failing requests → `err_count`=255. Assert `clear` together with `in_valid` → request not accepted, `err_count`=0, FIFO empty, `wr_addr`=BASE_ADDR.
- **Async reset mid-operation.** Assert `reset` between edges with 2 words buffered → `out_valid`=0 immediately; after release, no stale word is emitted.
